apb_two_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer in front of the APB master command port (`transfer`, `read_write`, `apb_write_paddr`, `apb_write_data`, `apb_read_paddr`, `apb_read_data_out`). It serialises read and write commands from two independent requesters onto the single master. It issues one `transfer` pulse per command and waits for master completion or timeout. It then returns read data, error status and a per-requester acknowledge.

---
 rtl/apb_two_port_arbiter_if.sv | 38 +++
 rtl/apb_two_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_apb_two_port_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_two_port_arbiter_if.sv
// Bus bundle between the two requesters / APB master and the arbiter.
// The slave modport is the arbiter's view: it serves the requesters and
// drives the command port of the APB master. The master modport is the
// environment's view (requesters plus APB master), as used by a testbench.
interface apb_two_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  // requester side
  logic [1:0]      req;
  logic [1:0]      rw;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      ack;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            busy;
  // APB master command side
  logic            transfer;
  logic            read_write;
  logic [AW-1:0]   apb_write_paddr;
  logic [DW-1:0]   apb_write_data;
  logic [AW-1:0]   apb_read_paddr;
  logic [DW-1:0]   apb_read_data_out;
  logic            m_done;

  modport slave (
    input  req, rw, addr, wdata, apb_read_data_out, m_done,
    output ack, rdata, err, busy, transfer, read_write,
           apb_write_paddr, apb_write_data, apb_read_paddr
  );

  modport master (
    output req, rw, addr, wdata, apb_read_data_out, m_done,
    input  ack, rdata, err, busy, transfer, read_write,
           apb_write_paddr, apb_write_data, apb_read_paddr
  );
endinterface

// File: rtl/apb_two_port_arbiter.sv
// Round-robin arbiter/sequencer serialising two requesters onto one APB
// master command port. One transfer strobe per command, bounded wait for
// completion, then a one-cycle ack to the owner with rdata/err.
//
// state | meaning
// IDLE  | no command in flight; arbitrate and latch the winner
// ISSUE | transfer strobe high, command presented to the master
// WAIT  | command held, waiting for m_done or timeout
// RESP  | ack to owner, rdata/err valid, round-robin pointer updated
module apb_two_port_arbiter #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input logic                   pclk,
  input logic                   preset,
  apb_two_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Last counter value still inside the wait window; reaching it without
  // m_done means TIMEOUT WAIT cycles have elapsed.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ack_q, ack_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          transfer_q, transfer_d;
  logic          read_write_q, read_write_d;
  logic [AW-1:0] wpaddr_q, wpaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] rpaddr_q, rpaddr_d;

  logic          grant;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // On a tie the requester that did not own the previous command wins.
  assign grant     = (&bus.req) ? ~last_q : bus.req[1];
  assign sel_addr  = grant ? bus.addr[AW +: AW] : bus.addr[0 +: AW];
  assign sel_wdata = grant ? bus.wdata[DW +: DW] : bus.wdata[0 +: DW];

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    ack_d        = 2'b00;
    rdata_d      = rdata_q;
    err_d        = err_q;
    busy_d       = busy_q;
    transfer_d   = 1'b0;
    read_write_d = read_write_q;
    wpaddr_d     = wpaddr_q;
    wdata_d      = wdata_q;
    rpaddr_d     = rpaddr_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d      = grant;
          busy_d       = 1'b1;
          transfer_d   = 1'b1;
          read_write_d = bus.rw[grant];
          if (bus.rw[grant]) begin
            wpaddr_d = sel_addr;
            wdata_d  = sel_wdata;
            rpaddr_d = '0;
          end else begin
            wpaddr_d = '0;
            wdata_d  = '0;
            rpaddr_d = sel_addr;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // m_done takes priority over a timeout in the same cycle.
        if (bus.m_done) begin
          rdata_d = read_write_q ? '0 : bus.apb_read_data_out;
          err_d   = 1'b0;
          ack_d   = owner_q ? 2'b10 : 2'b01;
          state_d = RESP;
        end else if (cnt_q >= CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          ack_d   = owner_q ? 2'b10 : 2'b01;
          state_d = RESP;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      RESP: begin
        last_d       = owner_q;
        busy_d       = 1'b0;
        read_write_d = 1'b0;
        wpaddr_d     = '0;
        wdata_d      = '0;
        rpaddr_d     = '0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      cnt_q        <= '0;
      ack_q        <= 2'b00;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      transfer_q   <= 1'b0;
      read_write_q <= 1'b0;
      wpaddr_q     <= '0;
      wdata_q      <= '0;
      rpaddr_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      transfer_q   <= transfer_d;
      read_write_q <= read_write_d;
      wpaddr_q     <= wpaddr_d;
      wdata_q      <= wdata_d;
      rpaddr_q     <= rpaddr_d;
    end
  end

  assign bus.ack             = ack_q;
  assign bus.rdata           = rdata_q;
  assign bus.err             = err_q;
  assign bus.busy            = busy_q;
  assign bus.transfer        = transfer_q;
  assign bus.read_write      = read_write_q;
  assign bus.apb_write_paddr = wpaddr_q;
  assign bus.apb_write_data  = wdata_q;
  assign bus.apb_read_paddr  = rpaddr_q;

endmodule

// File: tb/tb_apb_two_port_arbiter.sv
// Directed testbench for apb_two_port_arbiter (AW=9, DW=8, TIMEOUT=16).
module tb_apb_two_port_arbiter;

  logic pclk;
  logic preset;
  int   errors;
  int   checks;

  apb_two_port_arbiter_if #(.AW(9), .DW(8)) bus ();

  apb_two_port_arbiter #(.AW(9), .DW(8), .TIMEOUT(16)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // every DUT output in one vector: ack, rdata, err, busy, transfer,
  // read_write, write addr, write data, read addr
  logic [39:0] all_out;
  assign all_out = {bus.ack, bus.rdata, bus.err, bus.busy, bus.transfer,
                    bus.read_write, bus.apb_write_paddr, bus.apb_write_data,
                    bus.apb_read_paddr};

  // command port view: read_write, write addr, write data, read addr
  logic [26:0] cmd_out;
  assign cmd_out = {bus.read_write, bus.apb_write_paddr, bus.apb_write_data,
                    bus.apb_read_paddr};

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    preset                = 1'b1;
    bus.req               = 2'b00;
    bus.rw                = 2'b00;
    bus.addr              = '0;
    bus.wdata             = '0;
    bus.m_done            = 1'b0;
    bus.apb_read_data_out = '0;
    tick();
    tick();
    preset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (all_out !== 40'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", all_out, 40'h0);
    end
    tick();
    checks++;
    if (all_out !== 40'h0) begin
      errors++; $display("FAIL idle_outputs: got %h expected %h", all_out, 40'h0);
    end
  endtask

  task automatic test_single_write();
    bus.req   = 2'b01;
    bus.rw    = 2'b01;
    bus.addr  = {9'h000, 9'h005};
    bus.wdata = {8'h00, 8'hA5};
    tick(); // ISSUE
    checks++;
    if ({bus.transfer, bus.busy, cmd_out} !== {1'b1, 1'b1, 1'b1, 9'h005, 8'hA5, 9'h000}) begin
      errors++; $display("FAIL wr_issue: got %h expected %h", {bus.transfer, bus.busy, cmd_out},
                         {1'b1, 1'b1, 1'b1, 9'h005, 8'hA5, 9'h000});
    end
    tick(); // WAIT 1
    checks++;
    if ({bus.transfer, cmd_out} !== {1'b0, 1'b1, 9'h005, 8'hA5, 9'h000}) begin
      errors++; $display("FAIL wr_hold: got %h expected %h", {bus.transfer, cmd_out},
                         {1'b0, 1'b1, 9'h005, 8'hA5, 9'h000});
    end
    tick(); // WAIT 2, done two cycles after transfer
    bus.m_done = 1'b1;
    checks++;
    if (bus.ack !== 2'b00) begin
      errors++; $display("FAIL wr_early_ack: got %b expected %b", bus.ack, 2'b00);
    end
    tick(); // RESP
    bus.m_done = 1'b0;
    bus.req    = 2'b00;
    checks++;
    if ({bus.ack, bus.err, bus.rdata} !== {2'b01, 1'b0, 8'h00}) begin
      errors++; $display("FAIL wr_resp: got %h expected %h", {bus.ack, bus.err, bus.rdata},
                         {2'b01, 1'b0, 8'h00});
    end
    tick(); // IDLE
    checks++;
    if (all_out !== 40'h0) begin
      errors++; $display("FAIL wr_back_idle: got %h expected %h", all_out, 40'h0);
    end
  endtask

  task automatic test_read();
    bus.req   = 2'b10;
    bus.rw    = 2'b00;
    bus.addr  = {9'h105, 9'h000};
    bus.wdata = '0;
    tick(); // ISSUE
    checks++;
    if ({bus.transfer, cmd_out} !== {1'b1, 1'b0, 9'h000, 8'h00, 9'h105}) begin
      errors++; $display("FAIL rd_issue: got %h expected %h", {bus.transfer, cmd_out},
                         {1'b1, 1'b0, 9'h000, 8'h00, 9'h105});
    end
    tick(); // WAIT 1
    bus.m_done            = 1'b1;
    bus.apb_read_data_out = 8'h3C;
    tick(); // RESP
    bus.m_done            = 1'b0;
    bus.apb_read_data_out = 8'h00;
    bus.req               = 2'b00;
    checks++;
    if ({bus.ack, bus.err, bus.rdata} !== {2'b10, 1'b0, 8'h3C}) begin
      errors++; $display("FAIL rd_resp: got %h expected %h", {bus.ack, bus.err, bus.rdata},
                         {2'b10, 1'b0, 8'h3C});
    end
    tick(); // IDLE
    checks++;
    if ({bus.ack, bus.busy, bus.rdata} !== {2'b00, 1'b0, 8'h3C}) begin
      errors++; $display("FAIL rd_hold_rdata: got %h expected %h", {bus.ack, bus.busy, bus.rdata},
                         {2'b00, 1'b0, 8'h3C});
    end
  endtask

  task automatic test_timeout();
    int  n;
    bit  got;
    bus.req  = 2'b01;
    bus.rw   = 2'b00;
    bus.addr = {9'h000, 9'h0AA};
    tick(); // ISSUE
    checks++;
    if ({bus.transfer, bus.apb_read_paddr} !== {1'b1, 9'h0AA}) begin
      errors++; $display("FAIL to_issue: got %h expected %h", {bus.transfer, bus.apb_read_paddr},
                         {1'b1, 9'h0AA});
    end
    n   = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      tick();
      if (bus.ack !== 2'b00) begin
        got = 1'b1;
        n   = i;
      end
    end
    bus.req = 2'b00;
    checks++;
    if (n !== 17) begin
      errors++; $display("FAIL to_latency: got %0d cycles expected %0d", n, 17);
    end
    checks++;
    if ({bus.ack, bus.err, bus.rdata} !== {2'b01, 1'b1, 8'h00}) begin
      errors++; $display("FAIL to_resp: got %h expected %h", {bus.ack, bus.err, bus.rdata},
                         {2'b01, 1'b1, 8'h00});
    end
    tick(); // IDLE
    bus.m_done = 1'b1; // late done while idle
    tick();
    bus.m_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.ack, bus.busy, bus.err} !== {2'b00, 1'b0, 1'b1}) begin
        errors++; $display("FAIL to_late_done: got %h expected %h", {bus.ack, bus.busy, bus.err},
                           {2'b00, 1'b0, 1'b1});
      end
    end
  endtask

  task automatic test_done_at_timeout();
    bus.req  = 2'b01;
    bus.rw   = 2'b00;
    bus.addr = {9'h000, 9'h033};
    tick(); // ISSUE
    for (int i = 0; i < 16; i++) tick(); // WAIT cycle 16
    checks++;
    if ({bus.ack, bus.busy} !== {2'b00, 1'b1}) begin
      errors++; $display("FAIL sim_pre: got %h expected %h", {bus.ack, bus.busy}, {2'b00, 1'b1});
    end
    bus.m_done            = 1'b1;
    bus.apb_read_data_out = 8'hC3;
    tick(); // RESP
    bus.m_done            = 1'b0;
    bus.apb_read_data_out = 8'h00;
    bus.req               = 2'b00;
    checks++;
    if ({bus.ack, bus.err, bus.rdata} !== {2'b01, 1'b0, 8'hC3}) begin
      errors++; $display("FAIL sim_resp: got %h expected %h", {bus.ack, bus.err, bus.rdata},
                         {2'b01, 1'b0, 8'hC3});
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bus.req   = 2'b01;
    bus.rw    = 2'b01;
    bus.addr  = {9'h000, 9'h044};
    bus.wdata = {8'h00, 8'h99};
    tick(); // ISSUE
    checks++;
    if (bus.transfer !== 1'b1) begin
      errors++; $display("FAIL rst_issue: got %b expected %b", bus.transfer, 1'b1);
    end
    tick();
    tick();
    tick(); // WAIT 3
    preset = 1'b1;
    tick();
    checks++;
    if (all_out !== 40'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h expected %h", all_out, 40'h0);
    end
    preset  = 1'b0;
    bus.req = 2'b00;
    tick();
    bus.m_done = 1'b1; // stray done after abort
    tick();
    bus.m_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.ack, bus.busy} !== {2'b00, 1'b0}) begin
        errors++; $display("FAIL rst_stray_done: got %h expected %h", {bus.ack, bus.busy}, {2'b00, 1'b0});
      end
    end
    bus.req  = 2'b11;
    bus.rw   = 2'b00;
    bus.addr = {9'h1F0, 9'h00F};
    tick(); // ISSUE, requester 0 must win after reset
    checks++;
    if ({bus.transfer, cmd_out} !== {1'b1, 1'b0, 9'h000, 8'h00, 9'h00F}) begin
      errors++; $display("FAIL rst_first_tie: got %h expected %h", {bus.transfer, cmd_out},
                         {1'b1, 1'b0, 9'h000, 8'h00, 9'h00F});
    end
    tick();
    bus.m_done            = 1'b1;
    bus.apb_read_data_out = 8'h6E;
    tick(); // RESP
    bus.m_done            = 1'b0;
    bus.apb_read_data_out = 8'h00;
    bus.req               = 2'b00;
    checks++;
    if ({bus.ack, bus.err, bus.rdata} !== {2'b01, 1'b0, 8'h6E}) begin
      errors++; $display("FAIL rst_fresh_resp: got %h expected %h", {bus.ack, bus.err, bus.rdata},
                         {2'b01, 1'b0, 8'h6E});
    end
    tick();
  endtask

  task automatic test_contention();
    int       acks;
    int       xfers;
    logic     pend;
    logic [1:0]  exp_ack;
    logic [7:0]  exp_rdata;
    logic [26:0] exp_cmd;
    do_reset();
    bus.req               = 2'b11;
    bus.rw                = 2'b10; // port 1 writes, port 0 reads
    bus.addr              = {9'h1C3, 9'h011};
    bus.wdata             = {8'h77, 8'h00};
    bus.apb_read_data_out = 8'h5A;
    acks  = 0;
    xfers = 0;
    pend  = 1'b0;
    for (int cyc = 0; cyc < 60 && acks < 4; cyc++) begin
      tick();
      bus.m_done = pend;
      pend       = 1'b0;
      if (bus.transfer === 1'b1) begin
        exp_cmd = (xfers % 2 == 0) ? {1'b0, 9'h000, 8'h00, 9'h011}
                                   : {1'b1, 9'h1C3, 8'h77, 9'h000};
        checks++;
        if (cmd_out !== exp_cmd) begin
          errors++; $display("FAIL cont_grant%0d: got %h expected %h", xfers, cmd_out, exp_cmd);
        end
        xfers++;
        pend = 1'b1;
      end
      if (bus.ack !== 2'b00) begin
        exp_ack   = (acks % 2 == 0) ? 2'b01 : 2'b10;
        exp_rdata = (acks % 2 == 0) ? 8'h5A : 8'h00;
        checks++;
        if ({bus.ack, bus.err, bus.rdata} !== {exp_ack, 1'b0, exp_rdata}) begin
          errors++; $display("FAIL cont_ack%0d: got %h expected %h", acks,
                             {bus.ack, bus.err, bus.rdata}, {exp_ack, 1'b0, exp_rdata});
        end
        acks++;
        if (acks == 4) bus.req = 2'b00;
      end
    end
    bus.req    = 2'b00;
    bus.m_done = 1'b0;
    checks++;
    if (acks !== 4) begin
      errors++; $display("FAIL cont_ack_count: got %0d expected %0d", acks, 4);
    end
    checks++;
    if (xfers !== 4) begin
      errors++; $display("FAIL cont_transfer_count: got %0d expected %0d", xfers, 4);
    end
    tick();
    checks++;
    if ({bus.busy, bus.transfer, bus.ack} !== 4'b0000) begin
      errors++; $display("FAIL cont_end_idle: got %b expected %b", {bus.busy, bus.transfer, bus.ack}, 4'b0000);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    preset = 1'b1;
    test_reset();
    test_single_write();
    test_read();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid_wait();
    test_contention();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
